// File: rtl/kp_voice_alloc.sv
// Polyphonic voice allocator / trigger sequencer for Karplus-Strong string voices.
// Optional macro KP_VOICE_STEAL_EN: steal the oldest voice instead of dropping when all are busy.
module kp_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int TRIG_HOLD  = 8,
  parameter int MIN_DELAY  = 16,
  parameter int AGE_W      = 16
) (
  input  logic                     a_clk,
  input  logic                     reset_n,
  input  logic                     note_valid,
  output logic                     note_ready,
  input  logic                     note_on,
  input  logic [6:0]               note_key,
  input  logic [10:0]              note_delay,
  input  logic [6:0]               note_velocity,
  output logic [NUM_VOICES-1:0]    v_trig,
  output logic [11*NUM_VOICES-1:0] v_delay_length,
  output logic [7*NUM_VOICES-1:0]  v_velocity,
  output logic [NUM_VOICES-1:0]    v_busy,
  output logic                     steal_pulse,
  output logic                     drop_pulse,
  output logic [1:0]               dbg_state
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(TRIG_HOLD + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, LOAD, TRIG} state_t;

  state_t            state, state_nx;
  logic              lat_on;
  logic [6:0]        lat_key;
  logic [10:0]       lat_delay;
  logic [6:0]        lat_vel;
  logic [VW-1:0]     tgt;
  logic [CW-1:0]     cnt;
  logic [NUM_VOICES-1:0] busy;
  logic [6:0]        keys   [NUM_VOICES];
  logic [AGE_W-1:0]  ages   [NUM_VOICES];
  logic [10:0]       delays [NUM_VOICES];
  logic [6:0]        vels   [NUM_VOICES];

  logic              match_hit, free_hit;
  logic [VW-1:0]     match_idx, free_idx, sel_idx;
`ifdef KP_VOICE_STEAL_EN
  logic [VW-1:0]     old_idx;
  logic [AGE_W-1:0]  old_age;
`endif

  // Handshake: a request transfers on any a_clk edge where note_valid and note_ready
  // are both high; note_ready is high only in IDLE, so nothing is consumed while busy.
  assign note_ready = (state == IDLE) && reset_n;
  assign v_busy     = busy;
  assign dbg_state  = state;

  // Lowest-index busy key match and lowest-index free voice.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (busy[i] && keys[i] == lat_key) begin
        match_hit = 1'b1;
        match_idx = VW'(i);
      end
      if (!busy[i]) begin
        free_hit = 1'b1;
        free_idx = VW'(i);
      end
    end
    sel_idx = match_hit ? match_idx : free_idx;
  end

`ifdef KP_VOICE_STEAL_EN
  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    old_idx = '0;
    old_age = ages[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i] > old_age) begin
        old_age = ages[i];
        old_idx = VW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (note_valid) state_nx = SEARCH;
      SEARCH: begin
        if (!lat_on)
          state_nx = IDLE;
        else if (match_hit || free_hit)
          state_nx = LOAD;
        else begin
`ifdef KP_VOICE_STEAL_EN
          state_nx = LOAD;
`else
          state_nx = IDLE;
`endif
        end
      end
      LOAD:   state_nx = TRIG;
      TRIG:   if (cnt == CW'(TRIG_HOLD - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_on      <= 1'b0;
      lat_key     <= '0;
      lat_delay   <= '0;
      lat_vel     <= '0;
      tgt         <= '0;
      cnt         <= '0;
      busy        <= '0;
      steal_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        keys[i]   <= '0;
        ages[i]   <= '0;
        delays[i] <= '0;
        vels[i]   <= '0;
      end
    end else begin
      state       <= state_nx;
      steal_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (busy[i] && ages[i] != '1) ages[i] <= ages[i] + 1'b1;
      end
      case (state)
        IDLE: begin
          if (note_valid) begin
            // Zero velocity note-on behaves exactly like a note-off.
            lat_on    <= note_on && (note_velocity != 7'd0);
            lat_key   <= note_key;
            lat_delay <= note_delay;
            lat_vel   <= note_velocity;
          end
        end
        SEARCH: begin
          if (!lat_on) begin
            if (match_hit) begin
              busy[match_idx] <= 1'b0;
              ages[match_idx] <= '0;
            end
          end else if (match_hit || free_hit) begin
            tgt <= sel_idx;
          end else begin
`ifdef KP_VOICE_STEAL_EN
            tgt         <= old_idx;
            steal_pulse <= 1'b1;
`else
            drop_pulse  <= 1'b1;
`endif
          end
        end
        LOAD: begin
          delays[tgt] <= (lat_delay < 11'(MIN_DELAY)) ? 11'(MIN_DELAY) : lat_delay;
          vels[tgt]   <= lat_vel;
          keys[tgt]   <= lat_key;
          busy[tgt]   <= 1'b1;
          ages[tgt]   <= '0;
          cnt         <= '0;
        end
        TRIG: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    v_trig = '0;
    if (state == TRIG) v_trig[tgt] = 1'b1;
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign v_delay_length[11*g +: 11] = delays[g];
    assign v_velocity[7*g +: 7]       = vels[g];
  end

endmodule

// File: tb/tb_kp_voice_alloc.sv
// Directed bench for kp_voice_alloc: allocation, retrigger, clamp, note-off, full-bank and reset cases.
module tb_kp_voice_alloc;

  logic        a_clk = 1'b0;
  logic        reset_n;
  logic        note_valid;
  logic        note_ready;
  logic        note_on;
  logic [6:0]  note_key;
  logic [10:0] note_delay;
  logic [6:0]  note_velocity;
  logic [3:0]  v_trig;
  logic [43:0] v_delay_length;
  logic [27:0] v_velocity;
  logic [3:0]  v_busy;
  logic        steal_pulse;
  logic        drop_pulse;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  kp_voice_alloc dut (
    .a_clk          (a_clk),
    .reset_n        (reset_n),
    .note_valid     (note_valid),
    .note_ready     (note_ready),
    .note_on        (note_on),
    .note_key       (note_key),
    .note_delay     (note_delay),
    .note_velocity  (note_velocity),
    .v_trig         (v_trig),
    .v_delay_length (v_delay_length),
    .v_velocity     (v_velocity),
    .v_busy         (v_busy),
    .steal_pulse    (steal_pulse),
    .drop_pulse     (drop_pulse),
    .dbg_state      (dbg_state)
  );

  always #5 a_clk = ~a_clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge a_clk);
  endtask

  // Returns 1 ns after the handshake edge T; cyc(k) then samples in cycle T+k.
  task automatic send(input logic on, input logic [6:0] key, input logic [10:0] dly,
                      input logic [6:0] vel);
    int guard;
    guard = 0;
    @(negedge a_clk);
    while (!note_ready && guard < 100) begin
      @(negedge a_clk);
      guard++;
    end
    check("ready_wait", note_ready, 1);
    note_valid    = 1'b1;
    note_on       = on;
    note_key      = key;
    note_delay    = dly;
    note_velocity = vel;
    @(posedge a_clk);
    #1 note_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    note_valid = 1'b0;
    note_on = 1'b0;
    note_key = '0;
    note_delay = '0;
    note_velocity = '0;
    cyc(3);
    check("rst_ready_low", note_ready, 0);
    reset_n = 1'b1;
    cyc(1);
    check("rst_ready", note_ready, 1);
    check("rst_trig", v_trig, 0);
    check("rst_busy", v_busy, 0);
    check("rst_delay", v_delay_length, 0);
    check("rst_vel", v_velocity, 0);
    check("rst_pulses", {steal_pulse, drop_pulse}, 0);

    // First note: key 60 lands on voice 0
    send(1, 7'd60, 11'd200, 7'd100);
    cyc(2);
    check("a_trig_load", v_trig, 0);
    cyc(1);
    check("a_trig_first", v_trig, 4'b0001);
    check("a_delay0", v_delay_length[10:0], 200);
    check("a_vel0", v_velocity[6:0], 100);
    check("a_busy", v_busy, 4'b0001);
    cyc(7);
    check("a_trig_last", v_trig, 4'b0001);
    check("a_ready_last", note_ready, 0);
    cyc(1);
    check("a_trig_end", v_trig, 0);
    check("a_ready_end", note_ready, 1);

    // Same key retriggers voice 0 in place
    send(1, 7'd60, 11'd210, 7'd90);
    cyc(3);
    check("rt_trig", v_trig, 4'b0001);
    check("rt_busy", v_busy, 4'b0001);
    check("rt_delay0", v_delay_length[10:0], 210);
    cyc(8);

    // Short delay is clamped to the minimum
    send(1, 7'd61, 11'd5, 7'd40);
    cyc(3);
    check("clamp_trig", v_trig, 4'b0010);
    check("clamp_delay1", v_delay_length[21:11], 16);
    check("clamp_busy", v_busy, 4'b0011);
    cyc(8);

    // Velocity-0 note-on releases key 61 without a trigger
    send(1, 7'd61, 11'd300, 7'd0);
    cyc(1);
    check("v0_busy_search", v_busy, 4'b0011);
    cyc(1);
    check("v0_busy", v_busy, 4'b0001);
    check("v0_ready", note_ready, 1);
    check("v0_trig", v_trig, 0);
    cyc(1);
    check("v0_trig_after", v_trig, 0);
    check("v0_delay_kept", v_delay_length[21:11], 16);

    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    check("rst2_busy", v_busy, 0);
    check("rst2_delay", v_delay_length, 0);

    // Fill the bank
    send(1, 7'd60, 11'd100, 7'd10); cyc(11);
    send(1, 7'd62, 11'd110, 7'd11); cyc(11);
    send(1, 7'd64, 11'd120, 7'd12); cyc(11);
    send(1, 7'd65, 11'd130, 7'd13); cyc(11);
    check("fill_busy", v_busy, 4'b1111);
    check("fill_delay3", v_delay_length[43:33], 130);
    check("fill_vel2", v_velocity[20:14], 12);

    send(0, 7'd62, 11'd0, 7'd0);
    cyc(1);
    check("off_busy_search", v_busy, 4'b1111);
    check("off_ready_search", note_ready, 0);
    cyc(1);
    check("off_busy", v_busy, 4'b1101);
    check("off_ready", note_ready, 1);

    send(1, 7'd67, 11'd140, 7'd20);
    cyc(3);
    check("reuse_trig", v_trig, 4'b0010);
    check("reuse_busy", v_busy, 4'b1111);
    check("reuse_delay1", v_delay_length[21:11], 140);
    cyc(8);

    // Fifth note with every voice busy
    send(1, 7'd70, 11'd150, 7'd30);
    cyc(2);
`ifdef KP_VOICE_STEAL_EN
    check("full_steal", steal_pulse, 1);
    check("full_drop", drop_pulse, 0);
    check("full_ready", note_ready, 0);
    cyc(1);
    check("full_trig", v_trig, 4'b0001);
    check("full_steal_after", steal_pulse, 0);
    check("full_delay0", v_delay_length[10:0], 150);
    cyc(8);
`else
    check("full_drop", drop_pulse, 1);
    check("full_steal", steal_pulse, 0);
    check("full_ready", note_ready, 1);
    cyc(1);
    check("full_trig", v_trig, 0);
    check("full_drop_after", drop_pulse, 0);
    check("full_busy", v_busy, 4'b1111);
    check("full_delay0", v_delay_length[10:0], 100);
`endif

    // Note-off for the first key: ignored after a steal, honoured otherwise
    send(0, 7'd60, 11'd0, 7'd0);
    cyc(2);
`ifdef KP_VOICE_STEAL_EN
    check("old_off_busy", v_busy, 4'b1111);
`else
    check("old_off_busy", v_busy, 4'b1110);
`endif

    // Reset during the third trigger cycle
    send(1, 7'd72, 11'd160, 7'd50);
    cyc(5);
`ifdef KP_VOICE_STEAL_EN
    check("mid_trig", v_trig, 4'b0100);
`else
    check("mid_trig", v_trig, 4'b0001);
`endif
    reset_n = 1'b0;
    cyc(1);
    check("mid_rst_trig", v_trig, 0);
    check("mid_rst_busy", v_busy, 0);
    check("mid_rst_ready", note_ready, 0);
    reset_n = 1'b1;
    cyc(1);
    check("mid_rel_ready", note_ready, 1);
    check("mid_rel_trig", v_trig, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kp_voice_alloc.md
# kp_voice_alloc

Polyphonic voice allocator and trigger sequencer for a bank of Karplus-Strong string voices. It accepts note-on/note-off requests over a valid/ready handshake and assigns each note to a free voice. Before triggering, it loads that voice's delay length and velocity. It then issues a trigger held long enough for the voice's trigger debouncer to register it. It sits between the note front-end (key scanner / MIDI decoder) and the `NUM_VOICES` string voices, whose outputs are mixed downstream.

## Interface
- `NUM_VOICES`, 4 — number of string voices driven (2..8).
- `TRIG_HOLD`, 8 — cycles each voice trigger is held high (≥ 4 to pass the voice debouncer).
- `MIN_DELAY`, 16 — minimum delay length loaded into a voice.
- `AGE_W`, 16 — width of per-voice age counters.

Ports:
- `a_clk`  in  1  — audio-rate system clock.
- `reset_n`  in  1  — reset, synchronous, active-low.
- `note_valid`  in  1  — request present.
- `note_ready`  out  1  — allocator can accept a request.
- `note_on`  in  1  — 1 = note-on, 0 = note-off.
- `note_key`  in  7  — key number, used to match note-off and retrigger.
- `note_delay`  in  11  — string delay length (pitch).
- `note_velocity`  in  7  — unsigned velocity.
- `v_trig`  out  NUM_VOICES  — per-voice trigger level, active high.
- `v_delay_length`  out  11·NUM_VOICES  — packed per-voice delay; voice i at [11i+10:11i].
- `v_velocity`  out  7·NUM_VOICES  — packed per-voice velocity; voice i at [7i+6:7i].
- `v_busy`  out  NUM_VOICES  — voice currently holds a key.
- `steal_pulse`  out  1  — one-cycle pulse when a busy voice is reassigned.
- `drop_pulse`  out  1  — one-cycle pulse when a note-on is discarded.

## Operation
- State machine: IDLE, SEARCH, LOAD, TRIG.
- IDLE:
  - `note_ready` = 1.
  - On `note_valid`, latch key/delay/velocity/on, then go to SEARCH.
- Velocity rule: a note-on with velocity 0 is treated as a note-off.
- SEARCH, note-off:
  - Clear `v_busy` of the lowest-index voice whose stored key matches.
  - If no voice matches, ignore the request silently.
  - Go to IDLE.
- SEARCH, note-on: select the target voice by priority:
  1. A busy voice with the same key (retrigger in place).
  2. The lowest-index free voice.
  3. If all voices are busy, the steal/drop rule under Configuration applies.
  - A selected voice goes to LOAD; a dropped note goes to IDLE.
- LOAD:
  - Write `max(note_delay, MIN_DELAY)` and the velocity into the target voice's registers.
  - Store the key, set busy, and clear that voice's age.
  - Go to TRIG.
- TRIG:
  - Hold the target `v_trig` bit high for `TRIG_HOLD` cycles, then go to IDLE.
  - Only one `v_trig` bit is ever high at a time.
- Age counters:
  - Every busy voice increments its counter each cycle, saturating at all-ones.
  - Free voices hold 0.
  - Oldest voice = maximum age; ties resolve to the lowest index.
- Voice parameter registers change only in LOAD. They are stable throughout and after TRIG, and are retained after note-off so the string rings out.

## Timing
- Handshake at edge T (`note_valid` & `note_ready`).
  - SEARCH occupies cycle T+1.
  - LOAD occupies cycle T+2; new parameters are visible from T+3.
- Note-on: `v_trig[i]` is high for cycles T+3 … T+2+TRIG_HOLD. `note_ready` returns high at T+3+TRIG_HOLD.
- Note-off: `v_busy[i]` clears at T+2; `note_ready` is high at T+2.
- Dropped note: `drop_pulse` is high at T+2; `note_ready` is high at T+2.
- Steal: `steal_pulse` is high during the LOAD cycle (T+2).
- `note_ready` is low in SEARCH, LOAD and TRIG; `note_valid` during those states is not consumed.
- Reset values: `note_ready` = 0 while `reset_n` is low, 1 in the first cycle after release. `v_trig`, `v_busy`, `steal_pulse`, `drop_pulse`, all `v_delay_length` and `v_velocity`, ages and stored keys are all 0. State = IDLE.
- Reset asserted mid-TRIG: `v_trig` is 0 at the next edge and the pending note is lost.

## Configuration
- `KP_VOICE_STEAL_EN` defined:
  - A note-on with all voices busy steals the oldest voice and pulses `steal_pulse`.
  - That voice's key is overwritten, so a later note-off for the old key is ignored.
- `KP_VOICE_STEAL_EN` undefined:
  - A note-on with all voices busy is accepted and discarded, and pulses `drop_pulse`.
  - `steal_pulse` is tied to 0.

## Test plan
- Reset, then note-on key 60, delay 200, velocity 100:
  - `v_trig[0]` high for cycles T+3 … T+10.
  - `v_delay_length[0]` = 200, `v_velocity[0]` = 100, `v_busy` = 0001.
  - `note_ready` high at T+11.
- Note-on keys 60, 62, 64, 65, then note-off 62:
  - `v_busy` goes 1111, then 1101.
  - The next note-on (key 67) goes to voice 1.
- Note-on key 60 twice: the second retriggers voice 0 and `v_busy` stays 0001.
- Note-on with delay 5: `v_delay_length` = 16.
- Note-on with velocity 0 for a held key: handled as a note-off and no `v_trig`.
- Five note-ons with all voices busy:
  - With `KP_VOICE_STEAL_EN`, voice 0 (oldest) is retriggered and `steal_pulse` fires.
  - Without it, `drop_pulse` fires and `v_trig` stays 0.
  - `reset_n` low at TRIG cycle 3 forces `v_trig` = 0 and `v_busy` = 0 on the next edge.
